// File: rtl/alu_cc_pipe_if.sv
// Operation/result handshake bus for alu_cc_pipe.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_cc_pipe_if #(
    parameter int WIDTH = 64,
    parameter int OPW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_zf;
    logic             out_sf;
    logic             out_of;
    logic             out_illegal;
    logic [2:0]       cc;
    logic [2:0]       cnd_fun;
    logic             cnd;

    modport master (
        output in_valid, in_op, in_a, in_b, in_set_cc, out_ready, cnd_fun,
        input  in_ready, out_valid, out_res, out_zf, out_sf, out_of, out_illegal, cc, cnd
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_set_cc, out_ready, cnd_fun,
        output in_ready, out_valid, out_res, out_zf, out_sf, out_of, out_illegal, cc, cnd
    );
endinterface

// File: rtl/alu_cc_pipe.sv
// Two-stage pipelined Y86-64 execute ALU with condition-code register and jXX/cmovXX evaluator.
// Optional macro ALU_SHIFT_EN adds SHL (op 4) and SAR (op 5); without it those ops are illegal.
module alu_cc_pipe #(
    parameter int WIDTH = 64,
    parameter int OPW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_cc_pipe_if.slave  bus
);
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR = OPW'(3);
`ifdef ALU_SHIFT_EN
    localparam int             SHW    = $clog2(WIDTH);
    localparam logic [OPW-1:0] OP_SHL = OPW'(4);
    localparam logic [OPW-1:0] OP_SAR = OPW'(5);
`endif

    logic             r_s1_valid;
    logic [OPW-1:0]   r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_set_cc;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic             r_s2_zf;
    logic             r_s2_sf;
    logic             r_s2_of;
    logic             r_s2_illegal;

    logic [2:0]       r_cc;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_res;
    logic             w_of;
    logic             w_zf;
    logic             w_sf;
    logic             w_illegal;
    logic             w_cc_load;
    logic             w_lt;
    logic             w_cnd;

    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = w_s2_adv;
    assign w_in_ready = !r_s1_valid || w_s1_adv;

    always_comb begin
        w_res     = '0;
        w_of      = 1'b0;
        w_illegal = 1'b0;
        case (r_s1_op)
            OP_ADD: begin
                w_res = r_s1_a + r_s1_b;
                w_of  = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = r_s1_a - r_s1_b;
                w_of  = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_AND: w_res = r_s1_a & r_s1_b;
            OP_XOR: w_res = r_s1_a ^ r_s1_b;
`ifdef ALU_SHIFT_EN
            OP_SHL: w_res = r_s1_a << r_s1_b[SHW-1:0];
            OP_SAR: w_res = $signed(r_s1_a) >>> r_s1_b[SHW-1:0];
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // Illegal ops report all-zero flags, so ZF must not follow the zero result
    assign w_zf      = !w_illegal && (w_res == '0);
    assign w_sf      = w_res[WIDTH-1];
    assign w_cc_load = w_s2_adv && r_s1_valid && r_s1_set_cc && !w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_set_cc <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_op     <= bus.in_op;
                r_s1_a      <= bus.in_a;
                r_s1_b      <= bus.in_b;
                r_s1_set_cc <= bus.in_set_cc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_res     <= '0;
            r_s2_zf      <= 1'b0;
            r_s2_sf      <= 1'b0;
            r_s2_of      <= 1'b0;
            r_s2_illegal <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res     <= w_res;
                r_s2_zf      <= w_zf;
                r_s2_sf      <= w_sf;
                r_s2_of      <= w_of;
                r_s2_illegal <= w_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 3'b100;
        end else if (w_cc_load) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    // cc is {ZF,SF,OF}; signed less-than is SF^OF
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cnd = 1'b0;
        case (bus.cnd_fun)
            3'd0: w_cnd = 1'b1;
            3'd1: w_cnd = w_lt || r_cc[2];
            3'd2: w_cnd = w_lt;
            3'd3: w_cnd = r_cc[2];
            3'd4: w_cnd = !r_cc[2];
            3'd5: w_cnd = !w_lt;
            3'd6: w_cnd = !w_lt && !r_cc[2];
            default: w_cnd = 1'b0;
        endcase
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_s2_valid;
    assign bus.out_res     = r_s2_res;
    assign bus.out_zf      = r_s2_zf;
    assign bus.out_sf      = r_s2_sf;
    assign bus.out_of      = r_s2_of;
    assign bus.out_illegal = r_s2_illegal;
    assign bus.cc          = r_cc;
    assign bus.cnd         = w_cnd;
endmodule
